// File: rtl/pong_pkg.sv
// Shared types and default geometry for the pong VGA display path.
package pong_pkg;

  localparam int unsigned DEF_COLOR_W  = 4;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_V_ACTIVE = 480;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t BLACK = '0;

endpackage

// File: rtl/rect_hit.sv
// Combinational point-in-rectangle test: left/top edges exclusive, right edge inclusive, bottom exclusive.
module rect_hit #(
  parameter int unsigned CW = 16
) (
  input  logic          en,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] y1,
  input  logic [CW-1:0] h,
  input  logic [CW-1:0] v,
  output logic          hit
);

  // Degenerate rectangles (x1 <= x0, y1 <= y0 + 1) fall out of these compares as never-hit.
  assign hit = en && (x0 < h) && (h <= x1) && (y0 < v) && (v < y1);

endmodule

// File: rtl/rect_compositor.sv
// Prioritised rectangle-layer pixel compositor with per-frame shadow geometry and ball collision flags.
module rect_compositor import pong_pkg::*; #(
  parameter int unsigned NUM_RECTS = 4,
  parameter int unsigned CW        = 16,
  parameter int unsigned COLOR_W   = DEF_COLOR_W,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CW-1:0]                  h_counter,
  input  logic [CW-1:0]                  v_counter,
  input  logic [NUM_RECTS*CW-1:0]        rect_x0,
  input  logic [NUM_RECTS*CW-1:0]        rect_x1,
  input  logic [NUM_RECTS*CW-1:0]        rect_y0,
  input  logic [NUM_RECTS*CW-1:0]        rect_y1,
  input  logic [NUM_RECTS*3*COLOR_W-1:0] rect_color,
  input  logic [NUM_RECTS-1:0]           rect_en,
  input  logic [3*COLOR_W-1:0]           bg_color,
  output logic [COLOR_W-1:0]             red,
  output logic [COLOR_W-1:0]             green,
  output logic [COLOR_W-1:0]             blue,
  output logic [NUM_RECTS-1:0]           collision,
  output logic                           frame_done
);

  localparam int unsigned PIX_W = 3 * COLOR_W;

  logic [CW-1:0]        sh_x0    [NUM_RECTS];
  logic [CW-1:0]        sh_x1    [NUM_RECTS];
  logic [CW-1:0]        sh_y0    [NUM_RECTS];
  logic [CW-1:0]        sh_y1    [NUM_RECTS];
  logic [PIX_W-1:0]     sh_color [NUM_RECTS];
  logic [NUM_RECTS-1:0] sh_en;
  logic                 started;

  logic                 frame_start_c;
  logic                 frame_end_c;
  logic                 active_c;
  logic [NUM_RECTS-1:0] hit_c;

  logic [NUM_RECTS-1:0] hit_q;
  logic                 active_q;
  logic                 frame_end_q;

  logic [NUM_RECTS-1:0] sticky;
  logic [NUM_RECTS-1:0] sticky_next_c;
  logic [PIX_W-1:0]     pix_c;

  assign frame_start_c = (h_counter == '0) && (v_counter == '0);
  assign frame_end_c   = (h_counter == '0) && (v_counter == CW'(V_ACTIVE));
  // Nothing is visible until the first frame start after reset.
  assign active_c      = (started || frame_start_c)
                         && (h_counter < CW'(H_ACTIVE)) && (v_counter < CW'(V_ACTIVE));

  // The frame-start sample sees the incoming geometry directly, later samples the shadow copy.
  for (genvar i = 0; i < NUM_RECTS; i++) begin : g_layer
    logic          en_c;
    logic [CW-1:0] x0_c;
    logic [CW-1:0] x1_c;
    logic [CW-1:0] y0_c;
    logic [CW-1:0] y1_c;

    assign en_c = frame_start_c ? rect_en[i]            : sh_en[i];
    assign x0_c = frame_start_c ? rect_x0[i*CW +: CW]   : sh_x0[i];
    assign x1_c = frame_start_c ? rect_x1[i*CW +: CW]   : sh_x1[i];
    assign y0_c = frame_start_c ? rect_y0[i*CW +: CW]   : sh_y0[i];
    assign y1_c = frame_start_c ? rect_y1[i*CW +: CW]   : sh_y1[i];

    rect_hit #(.CW(CW)) u_hit (
      .en (en_c),
      .x0 (x0_c),
      .x1 (x1_c),
      .y0 (y0_c),
      .y1 (y1_c),
      .h  (h_counter),
      .v  (v_counter),
      .hit(hit_c[i])
    );
  end

  // Shadow enables and the started flag are the only shadow state that needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en   <= '0;
      started <= 1'b0;
    end else if (frame_start_c) begin
      sh_en   <= rect_en;
      started <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && frame_start_c) begin
      for (int i = 0; i < int'(NUM_RECTS); i++) begin
        sh_x0[i]    <= rect_x0[i*CW +: CW];
        sh_x1[i]    <= rect_x1[i*CW +: CW];
        sh_y0[i]    <= rect_y0[i*CW +: CW];
        sh_y1[i]    <= rect_y1[i*CW +: CW];
        sh_color[i] <= rect_color[i*PIX_W +: PIX_W];
      end
    end
  end

  // Stage 1: hit vector and frame flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q       <= '0;
      active_q    <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      hit_q       <= hit_c;
      active_q    <= active_c;
      frame_end_q <= frame_end_c;
    end
  end

  // Stage 2 combinational: priority colour pick and collision accumulation.
  always_comb begin
    sticky_next_c = sticky;
    pix_c         = bg_color;
    if (active_q && hit_q[0]) begin
      sticky_next_c = sticky | {hit_q[NUM_RECTS-1:1], 1'b0};
    end
    for (int i = int'(NUM_RECTS) - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        pix_c = sh_color[i];
      end
    end
    if (!active_q) begin
      pix_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      collision  <= '0;
      sticky     <= '0;
      frame_done <= 1'b0;
    end else begin
      {red, green, blue} <= pix_c;
      frame_done         <= frame_end_q;
      if (frame_end_q) begin
        collision <= sticky_next_c;
        sticky    <= '0;
      end else begin
        sticky    <= sticky_next_c;
      end
    end
  end

endmodule

// File: tb/tb_rect_compositor.sv
// Directed bench for rect_compositor: priority, edges, shadowing, collisions, enables and reset.
module tb_rect_compositor;
  import pong_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 16;
  localparam int IDLE_H = 700;
  localparam int IDLE_V = 10;

  localparam rgb_t RED   = '{r: 4'hf, g: 4'h0, b: 4'h0};
  localparam rgb_t GREEN = '{r: 4'h0, g: 4'hf, b: 4'h0};
  localparam rgb_t BLUE  = '{r: 4'h0, g: 4'h0, b: 4'hf};
  localparam rgb_t WHITE = '{r: 4'hf, g: 4'hf, b: 4'hf};
  localparam rgb_t BG    = '{r: 4'h1, g: 4'h2, b: 4'h3};

  logic            clk = 1'b0;
  logic            rst;
  logic [CW-1:0]   h_counter;
  logic [CW-1:0]   v_counter;
  logic [NR*CW-1:0] rect_x0, rect_x1, rect_y0, rect_y1;
  logic [NR*12-1:0] rect_color;
  logic [NR-1:0]   rect_en;
  logic [11:0]     bg_color;
  logic [3:0]      red, green, blue;
  logic [NR-1:0]   collision;
  logic            frame_done;

  int errors = 0;
  int checks = 0;

  rect_compositor #(.NUM_RECTS(NR), .CW(CW), .COLOR_W(4), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .rst(rst), .h_counter(h_counter), .v_counter(v_counter),
    .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
    .rect_color(rect_color), .rect_en(rect_en), .bg_color(bg_color),
    .red(red), .green(green), .blue(blue), .collision(collision), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v);
    h_counter = CW'(h);
    v_counter = CW'(v);
  endtask

  task automatic set_layer(input int i, input int x0, input int x1, input int y0, input int y1,
                           input rgb_t col, input logic en);
    rect_x0[i*CW +: CW]  = CW'(x0);
    rect_x1[i*CW +: CW]  = CW'(x1);
    rect_y0[i*CW +: CW]  = CW'(y0);
    rect_y1[i*CW +: CW]  = CW'(y1);
    rect_color[i*12 +: 12] = col;
    rect_en[i]           = en;
  endtask

  // One sample, then an idle cycle; RGB is checked two edges after the sample.
  task automatic pixel(input string tag, input int h, input int v, input rgb_t exp);
    drive(h, v);
    step();
    drive(IDLE_H, IDLE_V);
    step();
    check(tag, {red, green, blue}, exp);
  endtask

  task automatic frame_end(input string tag, input logic [NR-1:0] exp_col);
    drive(0, 480);
    step();
    drive(IDLE_H, IDLE_V);
    step();
    check({tag, "_done"}, frame_done, 1'b1);
    check({tag, "_col"}, collision, exp_col);
    step();
    check({tag, "_done_low"}, frame_done, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    drive(IDLE_H, IDLE_V);
    rect_x0 = '0; rect_x1 = '0; rect_y0 = '0; rect_y1 = '0;
    rect_color = '0; rect_en = '0;
    bg_color = BG;
    step();
    step();
    check("rst_rgb", {red, green, blue}, BLACK);
    check("rst_col", collision, 4'b0000);
    check("rst_done", frame_done, 1'b0);
    rst = 1'b0;
    pixel("black_before_start", 300, 300, BLACK);

    // Priority
    set_layer(0, 100, 110, 100, 110, RED, 1'b1);
    set_layer(1, 90, 200, 90, 200, GREEN, 1'b1);
    set_layer(2, 0, 0, 0, 0, BLUE, 1'b0);
    set_layer(3, 0, 0, 0, 0, WHITE, 1'b0);
    pixel("start_bg", 0, 0, BG);
    pixel("prio_l0", 105, 105, RED);
    pixel("prio_l1", 150, 150, GREEN);
    pixel("prio_bg", 300, 300, BG);
    pixel("l0_left_edge", 100, 105, GREEN);
    pixel("l0_bottom_edge", 110, 110, GREEN);
    pixel("l0_corner", 110, 109, RED);
    frame_end("fe_prio", 4'b0010);

    // Boundaries
    set_layer(1, 70, 80, 400, 500, GREEN, 1'b1);
    pixel("bnd_start", 0, 0, BG);
    pixel("bnd_h70", 70, 450, BG);
    pixel("bnd_h71", 71, 450, GREEN);
    pixel("bnd_h80", 80, 450, GREEN);
    pixel("bnd_h81", 81, 450, BG);
    pixel("bnd_v400", 75, 400, BG);
    pixel("bnd_v401", 75, 401, GREEN);
    pixel("bnd_v479", 75, 479, GREEN);
    pixel("bnd_v500", 75, 500, BLACK);
    pixel("bnd_v480", 75, 480, BLACK);
    pixel("bnd_h640", 640, 450, BLACK);
    pixel("bnd_last", 639, 479, BG);
    frame_end("fe_bnd", 4'b0000);

    // Shadow
    set_layer(1, 400, 600, 100, 470, GREEN, 1'b1);
    pixel("sh_start", 0, 0, BG);
    pixel("sh_in", 500, 150, GREEN);
    pixel("sh_out", 300, 150, BG);
    set_layer(1, 0, 600, 100, 470, GREEN, 1'b1);
    pixel("sh_mid_row250", 300, 250, BG);
    pixel("sh_mid_row469", 300, 469, BG);
    pixel("sh_mid_in", 500, 469, GREEN);
    frame_end("fe_sh1", 4'b0000);
    pixel("sh_start2", 0, 0, BG);
    pixel("sh_new_row250", 300, 250, GREEN);
    pixel("sh_new_left", 1, 101, GREEN);
    frame_end("fe_sh2", 4'b0000);

    // Collision
    rect_en[1] = 1'b0;
    set_layer(2, 95, 105, 95, 105, BLUE, 1'b1);
    pixel("col_start", 0, 0, BG);
    pixel("col_overlap", 103, 103, RED);
    pixel("col_l2", 96, 96, BLUE);
    frame_end("fe_col1", 4'b0100);
    set_layer(2, 300, 310, 300, 310, BLUE, 1'b1);
    pixel("col2_start", 0, 0, BG);
    pixel("col2_l0", 103, 103, RED);
    pixel("col2_l2", 305, 305, BLUE);
    check("col_held", collision, 4'b0100);
    frame_end("fe_col2", 4'b0000);

    // Disabled layer, then enabled
    set_layer(3, 95, 120, 95, 120, WHITE, 1'b0);
    pixel("dis_start", 0, 0, BG);
    pixel("dis_l0", 103, 103, RED);
    pixel("dis_l3", 115, 115, BG);
    frame_end("fe_dis", 4'b0000);
    rect_en[3] = 1'b1;
    pixel("en_start", 0, 0, BG);
    pixel("en_l3", 115, 115, WHITE);
    pixel("en_l0", 103, 103, RED);
    frame_end("fe_en", 4'b1000);

    // Reset mid-frame
    pixel("rs_start", 0, 0, BG);
    pixel("rs_hit", 103, 103, RED);
    drive(103, 103);
    step();
    rst = 1'b1;
    drive(300, 240);
    step();
    check("rs_rgb", {red, green, blue}, BLACK);
    check("rs_col", collision, 4'b0000);
    check("rs_done", frame_done, 1'b0);
    rst = 1'b0;
    pixel("rs_black", 300, 240, BLACK);
    pixel("rs_black_l0", 103, 103, BLACK);
    frame_end("fe_rs", 4'b0000);
    pixel("rs_restart", 0, 0, BG);
    pixel("rs_after_l0", 103, 103, RED);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_compositor.md
# rect_compositor

Parametrised pixel compositor for the VGA pong display. It generalises the fixed ball-plus-two-paddles colour logic to NUM_RECTS prioritised rectangle layers, each with its own colour and enable. Geometry is held in per-frame shadow registers so nothing tears mid-frame. Pixel output is registered with fixed latency, and rectangle 0 (the ball) is checked against every other layer, with per-frame collision flags reported. It sits between the timing counters and the VGA RGB pins.

## Interface
Parameters:
- NUM_RECTS, 4, number of layers (2..8); index 0 is highest priority and is the collision reference
- CW, 16, width of counters and coordinates
- COLOR_W, 4, bits per colour channel
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- h_counter  in  CW  current horizontal position
- v_counter  in  CW  current vertical position
- rect_x0, rect_x1  in  NUM_RECTS*CW  left/right edges; layer i occupies slice i
- rect_y0, rect_y1  in  NUM_RECTS*CW  top/bottom edges
- rect_color  in  NUM_RECTS*3*COLOR_W  {r,g,b} per layer
- rect_en  in  NUM_RECTS  layer enable
- bg_color  in  3*COLOR_W  {r,g,b} for active pixels not covered by any layer
- red, green, blue  out  COLOR_W each  registered pixel colour
- collision  out  NUM_RECTS  bit k=1: layer 0 overlapped layer k in the last complete frame; bit 0 is always 0
- frame_done  out  1  one-cycle pulse when collision updates

## Operation
- **Frame start:** a sample with h_counter==0 and v_counter==0. On that edge, rect_x0/x1/y0/y1/color/en are copied into shadow registers. All hit tests for that sample and later samples use the shadow values; the (0,0) sample itself uses the newly loaded values through a bypass.
- **Hit test:** layer i is hit when en_i, x0_i < h ≤ x1_i, and y0_i < v < y1_i. Compares are unsigned, CW bits. If x1 ≤ x0 or y1 ≤ y0 + 1, the layer is empty and never hits.
- **Active area:** h < H_ACTIVE and v < V_ACTIVE. Outside it, RGB = 0 and no collision is recorded.
- **Colour select:** within the active area, the lowest-index hit layer's colour is used. If no layer is hit, bg_color is used.
- **Collision:** during active pixels, if layer 0 and layer k≥1 are both hit, sticky bit k is set.
- **Frame end:** a sample with v_counter==V_ACTIVE and h_counter==0. At this point collision ← sticky, sticky clears, and frame_done pulses.
- Inputs need no settling outside frame start. Mid-frame changes are ignored until the next frame start.

## Timing
- **Stage 1 (edge N):** registers the hit vector, the active flag, and the frame-end flag from the sample at N.
- **Stage 2 (edge N+1):** registers RGB, updates sticky/collision, and drives frame_done.
- Latency is 2 clocks from h/v sample to RGB. frame_done asserts 2 clocks after the frame-end sample, for exactly 1 clock. Throughput is 1 pixel per clock.
- **Reset:** RGB=0, collision=0, frame_done=0, sticky=0, pipeline flags=0, all shadow enables=0.
  - The display stays black, not bg_color, until the first frame start (active flag cleared).
- **Reset mid-frame:** all state clears on the next edge. Collisions of the partial frame are lost.
- If frame start and frame end coincide (V_ACTIVE=0, illegal configuration), frame end wins. The shadow load still occurs.
- A sticky-set on the same stage-2 edge as the frame-end transfer is included in the transferred value. Clearing then applies.

## Structure
- Shared package `pong_pkg`:
  - rgb struct
  - COLOR_W default
  - H_ACTIVE/V_ACTIVE defaults
  - black constant
- Sub-module `rect_hit`: one CW-parameterised combinational hit test (en, x0, x1, y0, y1, h, v → hit), instantiated NUM_RECTS times via generate.
- Priority select and collision logic are inline in rect_compositor.

## Test plan
- **Priority:** NUM_RECTS=4. L0 (100,100)-(110,110) red; L1 (90,90)-(200,200) green. Sample (105,105) → RGB=f,0,0 two clocks later. Sample (150,150) → 0,f,0. Sample (300,300) → bg_color.
- **Boundaries:** L1 x0=70, x1=80, y0=400, y1=500. h=70 → no hit; h=71 and h=80 → hit; v=500 → no hit. Pixels at h=640 or v=480 → RGB=0 regardless of layers.
- **Shadow:** change L1 x0 from 400 to 0 mid-frame at v=200. Rows 200..479 still use 400. The next frame uses 0 from pixel (0,0).
- **Collision:** overlap L0 with L2 in frame 1 only. At the frame-end sample (0,480)+2 clocks, frame_done=1 and collision=4'b0100. At the end of frame 2, collision=4'b0000.
- **Disabled layer:** L0 overlaps L3 with rect_en[3]=0 → no L3 colour and collision[3]=0.
- **Reset:** assert rst at v=240 for 1 clock. Next edge: RGB=0, collision=0, frame_done=0. Output stays black until after the next (0,0) sample.
